floating_point_accumulator: RTL and testbench

// Streaming reduction stage directly downstream of floating_point_adder; it owns the running sum and feeds it back as operand a.
// - Accepts a packet of floats on a valid/ready stream, terminated by in_last.
// - Sums the packet sequentially: sum = x0 (+/-) x1 (+/-) ... (+/-) xN.
// - Presents the sum, element count and sticky exception flags on a registered valid/ready output.

---
 rtl/float_pkg.sv | 23 ++
 rtl/floating_point_accumulator_if.sv | 28 ++
 rtl/floating_point_adder.sv | 138 +++++++++++++
 rtl/floating_point_accumulator.sv | 106 ++++++++++
 tb/tb_floating_point_accumulator.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared float definitions for the adder and the streaming accumulator.
package float_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } acc_state_e;

    function automatic int float_width(input int ew, input int mw);
        return ew + mw + 1;
    endfunction

    // Constants are built 64 bits wide and truncated by the caller to its float width.
    function automatic logic [63:0] quiet_nan(input int ew, input int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction

    function automatic logic [63:0] signed_zero(input logic sign, input int ew, input int mw);
        return {63'd0, sign} << (ew + mw);
    endfunction

endpackage

// File: rtl/floating_point_accumulator_if.sv
// Input beat stream and registered result stream of the accumulator.
interface floating_point_accumulator_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_subtract;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_underflow;
    logic          out_overflow;
    logic          out_invalid;

    modport master (
        output in_valid, in_data, in_subtract, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_underflow, out_overflow, out_invalid
    );

    modport slave (
        input  in_valid, in_data, in_subtract, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_underflow, out_overflow, out_invalid
    );
endinterface

// File: rtl/floating_point_adder.sv
// Combinational IEEE-style float adder: align, add/sub, normalise, round (RNE or truncate).
// underflow_flag marks a nonzero subnormal result; overflow_flag a finite-operand overflow.
module floating_point_adder
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH                = 8,
    parameter int MANTISSA_WIDTH                = 23,
    parameter bit ROUND_TO_NEAREST_TIES_TO_EVEN = 1'b1,
    parameter bit IGNORE_SIGN_BIT_FOR_NAN       = 1'b1,
    localparam int W = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         subtract,
    output logic [W-1:0] result,
    output logic         underflow_flag,
    output logic         overflow_flag,
    output logic         invalid_operation_flag
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int SW = M + 4;
    localparam logic [E-1:0]   EXP_MAX   = '1;
    localparam logic [E-1:0]   EXP_MAXM1 = EXP_MAX - 1'b1;
    localparam logic [E-1:0]   EXP_ONE   = E'(1);
    localparam logic [E+1:0]   EXP_X_ONE = (E+2)'(1);
    localparam logic [W-1:0]   QNAN      = W'(quiet_nan(E, M));

    logic          sa, sb, sb_eff;
    logic [E-1:0]  ea, eb;
    logic [M-1:0]  fa, fb;
    logic          nan_a, nan_b, inf_a, inf_b, snan_a, snan_b;
    logic          a_ge_b, s_big, eff_sub;
    logic [E-1:0]  e_big, e_small, eb_adj, es_adj, diff;
    logic [M-1:0]  f_big, f_small;
    logic [SW-1:0] man_big, man_small, man_small_al, norm;
    logic [2*SW-1:0] wide;
    logic [SW:0]   sum;
    logic [E+1:0]  exp_r, exp_f;
    logic [M+1:0]  rounded;
    logic [M-1:0]  frac_f;
    logic          round_up;
    int            shamt;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign sb_eff = sb ^ subtract;

    always_comb begin
        nan_a  = (ea == EXP_MAX) && (fa != '0);
        nan_b  = (eb == EXP_MAX) && (fb != '0);
        inf_a  = (ea == EXP_MAX) && (fa == '0);
        inf_b  = (eb == EXP_MAX) && (fb == '0);
        snan_a = nan_a && !fa[M-1];
        snan_b = nan_b && !fb[M-1];

        a_ge_b  = {ea, fa} >= {eb, fb};
        s_big   = a_ge_b ? sa : sb_eff;
        e_big   = a_ge_b ? ea : eb;
        e_small = a_ge_b ? eb : ea;
        f_big   = a_ge_b ? fa : fb;
        f_small = a_ge_b ? fb : fa;
        eff_sub = sa ^ sb_eff;

        // Subnormals carry no hidden bit and share the exponent of the smallest normal.
        man_big   = {(e_big != '0), f_big, 3'b000};
        man_small = {(e_small != '0), f_small, 3'b000};
        eb_adj    = (e_big == '0) ? EXP_ONE : e_big;
        es_adj    = (e_small == '0) ? EXP_ONE : e_small;
        diff      = eb_adj - es_adj;
        shamt     = (int'(diff) > SW) ? SW : int'(diff);

        wide         = {man_small, {SW{1'b0}}} >> shamt;
        man_small_al = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

        sum = eff_sub ? ({1'b0, man_big} - {1'b0, man_small_al})
                      : ({1'b0, man_big} + {1'b0, man_small_al});

        if (sum[SW]) begin
            norm  = {sum[SW:2], sum[1] | sum[0]};
            exp_r = {2'b00, eb_adj} + EXP_X_ONE;
        end else begin
            norm  = sum[SW-1:0];
            exp_r = {2'b00, eb_adj};
            for (int i = 0; i < SW; i++) begin
                if (!norm[SW-1] && (exp_r > EXP_X_ONE)) begin
                    norm  = norm << 1;
                    exp_r = exp_r - EXP_X_ONE;
                end
            end
        end

        round_up = ROUND_TO_NEAREST_TIES_TO_EVEN && norm[2] && (norm[1] || norm[0] || norm[3]);
        rounded  = {1'b0, norm[SW-1:3]} + {{(M+1){1'b0}}, round_up};

        if (rounded[M+1]) begin
            exp_f  = exp_r + EXP_X_ONE;
            frac_f = rounded[M:1];
        end else begin
            exp_f  = rounded[M] ? exp_r : '0;
            frac_f = rounded[M-1:0];
        end

        underflow_flag         = 1'b0;
        overflow_flag          = 1'b0;
        invalid_operation_flag = 1'b0;

        if (exp_f >= {2'b00, EXP_MAX}) begin
            overflow_flag = 1'b1;
            result = ROUND_TO_NEAREST_TIES_TO_EVEN ? {s_big, EXP_MAX, {M{1'b0}}}
                                                   : {s_big, EXP_MAXM1, {M{1'b1}}};
        end else if (rounded == '0) begin
            // Exact cancellation yields +0; only -0 + -0 keeps the sign.
            result = {eff_sub ? 1'b0 : s_big, {(W-1){1'b0}}};
        end else begin
            underflow_flag = (exp_f == '0);
            result = {s_big, exp_f[E-1:0], frac_f};
        end

        if (nan_a || nan_b) begin
            result = QNAN;
            if (!IGNORE_SIGN_BIT_FOR_NAN) result[W-1] = nan_a ? sa : sb;
            underflow_flag         = 1'b0;
            overflow_flag          = 1'b0;
            invalid_operation_flag = snan_a || snan_b;
        end else if (inf_a || inf_b) begin
            underflow_flag = 1'b0;
            overflow_flag  = 1'b0;
            if (inf_a && inf_b && (sa != sb_eff)) begin
                result                 = QNAN;
                invalid_operation_flag = 1'b1;
            end else begin
                result = inf_a ? {sa, EXP_MAX, {M{1'b0}}} : {sb_eff, EXP_MAX, {M{1'b0}}};
            end
        end
    end

endmodule

// File: rtl/floating_point_accumulator.sv
// Packet-wise float reduction: sums beats until in_last, then holds the result for handoff.
// state  | meaning
// IDLE   | waiting for first beat; it loads acc directly, bypassing the adder
// ACCUM  | adding further beats into acc through the adder
// OUTPUT | result registers valid, waiting for out_ready
module floating_point_accumulator
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH                = 8,
    parameter int MANTISSA_WIDTH                = 23,
    parameter bit ROUND_TO_NEAREST_TIES_TO_EVEN = 1'b1,
    parameter bit IGNORE_SIGN_BIT_FOR_NAN       = 1'b1,
    parameter int COUNT_WIDTH                   = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    floating_point_accumulator_if.slave bus
);
    localparam int W = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH);
    localparam logic [W-1:0] POS_ZERO = W'(signed_zero(1'b0, EXPONENT_WIDTH, MANTISSA_WIDTH));

    acc_state_e             state, state_nxt;
    logic [W-1:0]           acc, acc_nxt, sum;
    logic [COUNT_WIDTH-1:0] count, count_nxt, count_inc;
    logic                   uf, of, inv, uf_nxt, of_nxt, inv_nxt;
    logic                   add_uf, add_of, add_inv;
    logic                   accept;

    floating_point_adder #(
        .EXPONENT_WIDTH               (EXPONENT_WIDTH),
        .MANTISSA_WIDTH               (MANTISSA_WIDTH),
        .ROUND_TO_NEAREST_TIES_TO_EVEN(ROUND_TO_NEAREST_TIES_TO_EVEN),
        .IGNORE_SIGN_BIT_FOR_NAN      (IGNORE_SIGN_BIT_FOR_NAN)
    ) u_adder (
        .a                     (acc),
        .b                     (bus.in_data),
        .subtract              (bus.in_subtract),
        .result                (sum),
        .underflow_flag        (add_uf),
        .overflow_flag         (add_of),
        .invalid_operation_flag(add_inv)
    );

    assign count_inc     = (count == '1) ? count : count + 1'b1;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state == OUTPUT);

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        acc_nxt      = bus.in_data;
        count_nxt    = COUNT_WIDTH'(1);
        uf_nxt       = 1'b0;
        of_nxt       = 1'b0;
        inv_nxt      = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                bus.in_ready = rst_n;
                if (bus.in_valid && rst_n) state_nxt = bus.in_last ? OUTPUT : ACCUM;
                if (state == ACCUM) begin
                    acc_nxt   = sum;
                    count_nxt = count_inc;
                    uf_nxt    = uf | add_uf;
                    of_nxt    = of | add_of;
                    inv_nxt   = inv | add_inv;
                end
            end
            OUTPUT: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            acc               <= POS_ZERO;
            count             <= '0;
            uf                <= 1'b0;
            of                <= 1'b0;
            inv               <= 1'b0;
            bus.out_data      <= '0;
            bus.out_count     <= '0;
            bus.out_underflow <= 1'b0;
            bus.out_overflow  <= 1'b0;
            bus.out_invalid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc   <= acc_nxt;
                count <= count_nxt;
                uf    <= uf_nxt;
                of    <= of_nxt;
                inv   <= inv_nxt;
            end
            // Result registers only move when a packet completes.
            if (accept && bus.in_last) begin
                bus.out_data      <= acc_nxt;
                bus.out_count     <= count_nxt;
                bus.out_underflow <= uf_nxt;
                bus.out_overflow  <= of_nxt;
                bus.out_invalid   <= inv_nxt;
            end
        end
    end

endmodule

// File: tb/tb_floating_point_accumulator.sv
// Directed bench for floating_point_accumulator: packet vector table plus handoff/reset/saturation sequences.
module tb_floating_point_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    floating_point_accumulator_if #(.W(32), .CW(16)) bus ();
    floating_point_accumulator_if #(.W(32), .CW(2))  bus_s ();

    floating_point_accumulator dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    floating_point_accumulator #(.COUNT_WIDTH(2)) dut_sat (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_s)
    );

    typedef struct packed {
        int               n;
        logic [2:0][31:0] data;
        logic [2:0]       sub;
        logic [31:0]      exp_data;
        logic [15:0]      exp_count;
        logic [2:0]       exp_flags;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [2:0] sub,
                                input logic [31:0] ed, input logic [15:0] ec, input logic [2:0] ef);
        vec_t v;
        v.n         = n;
        v.data      = {d2, d1, d0};
        v.sub       = sub;
        v.exp_data  = ed;
        v.exp_count = ec;
        v.exp_flags = ef;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [31:0] d, input logic sub, input logic last, input string name);
        int t = 0;
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.in_subtract = sub;
        bus.in_last     = last;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: in_ready stayed 0, required 1", name);
        end
        @(negedge clk);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_subtract = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_subtract = 1'b0; bus_s.in_last = 1'b0; bus_s.out_ready = 1'b0;

        #2;
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", bus.out_data, 32'h0);
        check("reset out_count", 32'(bus.out_count), 32'd0);
        check("reset flags", 32'({bus.out_underflow, bus.out_overflow, bus.out_invalid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", 32'(bus.in_ready), 32'd1);

        //           n  d0            d1            d2            sub     out_data      cnt flags{uf,of,inv}
        vecs[0]  = mk(3, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 32'h40C00000, 3, 3'b000);
        vecs[1]  = mk(1, 32'h80000000, 32'h0,        32'h0,        3'b000, 32'h80000000, 1, 3'b000);
        vecs[2]  = mk(2, 32'h40400000, 32'h40400000, 32'h0,        3'b010, 32'h00000000, 2, 3'b000);
        vecs[3]  = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        3'b000, 32'h7F800000, 2, 3'b010);
        vecs[4]  = mk(1, 32'h7F800000, 32'h0,        32'h0,        3'b001, 32'h7F800000, 1, 3'b000);
        vecs[5]  = mk(3, 32'h7F800000, 32'h7F800000, 32'h3F800000, 3'b010, 32'h7FC00000, 3, 3'b001);
        vecs[6]  = mk(2, 32'h00800000, 32'h00400001, 32'h0,        3'b010, 32'h003FFFFF, 2, 3'b100);
        vecs[7]  = mk(2, 32'h3F800000, 32'h33800000, 32'h0,        3'b000, 32'h3F800000, 2, 3'b000);
        vecs[8]  = mk(2, 32'h3F800000, 32'h33800001, 32'h0,        3'b000, 32'h3F800001, 2, 3'b000);
        vecs[9]  = mk(3, 32'h40A00000, 32'h3F800000, 32'h3F000000, 3'b010, 32'h40900000, 3, 3'b000);
        vecs[10] = mk(2, 32'hBF800000, 32'h3F800000, 32'h0,        3'b010, 32'hC0000000, 2, 3'b000);
        vecs[11] = mk(2, 32'h80000000, 32'h80000000, 32'h0,        3'b000, 32'h80000000, 2, 3'b000);

        for (int i = 0; i < 12; i++) begin
            for (int b = 0; b < vecs[i].n; b++)
                send_beat(vecs[i].data[b], vecs[i].sub[b], (b == vecs[i].n - 1), $sformatf("v%0d b%0d", i, b));
            bus.in_valid = 1'b0;
            check($sformatf("v%0d out_valid latency", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d out_data", i), bus.out_data, vecs[i].exp_data);
            check($sformatf("v%0d out_count", i), 32'(bus.out_count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d flags", i), 32'({bus.out_underflow, bus.out_overflow, bus.out_invalid}),
                  32'(vecs[i].exp_flags));
            release_result();
            check($sformatf("v%0d out_valid after handoff", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure in OUTPUT with the next packet already waiting.
        send_beat(32'h40400000, 1'b0, 1'b0, "bp b0");
        send_beat(32'h3F800000, 1'b0, 1'b1, "bp b1");
        bus.in_valid = 1'b1; bus.in_data = 32'h40A00000; bus.in_subtract = 1'b0; bus.in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp c%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp c%0d out_data", c), bus.out_data, 32'h40800000);
            check($sformatf("bp c%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        release_result();
        check("bp after pulse out_valid", 32'(bus.out_valid), 32'd0);
        check("bp after pulse in_ready", 32'(bus.in_ready), 32'd1);
        check("bp after pulse out_data held", bus.out_data, 32'h40800000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp next out_valid", 32'(bus.out_valid), 32'd1);
        check("bp next out_data", bus.out_data, 32'h40A00000);
        check("bp next out_count", 32'(bus.out_count), 32'd1);
        release_result();

        // Asynchronous reset in the middle of a packet.
        send_beat(32'h40400000, 1'b0, 1'b0, "rst b0");
        send_beat(32'h40000000, 1'b0, 1'b0, "rst b1");
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst in_ready", 32'(bus.in_ready), 32'd0);
        check("mid rst out_data", bus.out_data, 32'h0);
        check("mid rst out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(32'h3F800000, 1'b0, 1'b1, "post rst b0");
        bus.in_valid = 1'b0;
        check("post rst out_valid", 32'(bus.out_valid), 32'd1);
        check("post rst out_data", bus.out_data, 32'h3F800000);
        check("post rst out_count", 32'(bus.out_count), 32'd1);
        release_result();

        // Count saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_data  = 32'h3F800000;
            bus_s.in_last  = (i == 4);
            @(negedge clk);
        end
        bus_s.in_valid = 1'b0;
        check("sat out_valid", 32'(bus_s.out_valid), 32'd1);
        check("sat out_count", 32'(bus_s.out_count), 32'd3);
        check("sat out_data", bus_s.out_data, 32'h40A00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
